// File: rtl/strobe_compare.sv
`default_nettype none
// ============================================================================
// Module      : strobe_compare
// Description : Receive-side pin strobe. Samples one asynchronous DUT output
//               per tester cycle through a synchronizer, compares it against
//               the latched expected value (EDGE or WINDOW strobe), applies
//               the mask and accumulates per-vector pass/fail results.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_compare #(
    parameter int SYNC_STAGES = 2,
    parameter int VEC_W       = 16,
    parameter int FCNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [7:0]        cycle_length_i,
    input  logic [6:0]        strobe_edge_i,
    input  logic [6:0]        window_close_i,
    input  logic              cmp_mode_i,
    input  logic              dut_q_i,
    input  logic              exp_i,
    input  logic              mask_i,
    input  logic              clr_results_i,
    output logic              result_valid_o,
    output logic              fail_o,
    output logic [FCNT_W-1:0] fail_count_o,
    output logic              first_fail_valid_o,
    output logic [VEC_W-1:0]  first_fail_vec_o,
    output logic [VEC_W-1:0]  vec_index_o
);

    // Synchronizer chain; the last stage is the value that gets compared.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_w;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            assign sync_d = dut_q_i;
        end else begin : g_sync_chain
            assign sync_d = {sync_q[SYNC_STAGES-2:0], dut_q_i};
        end
    endgenerate

    assign s_w = sync_q[SYNC_STAGES-1];

    // Tester-cycle timing and per-vector compare state.
    logic [7:0]        cnt_q, cnt_d;
    logic              exp_q, exp_d;
    logic              mask_q, mask_d;
    logic              mism_q, mism_d;

    // Accumulated results.
    logic              valid_q, valid_d;
    logic              fail_q, fail_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              ffv_q, ffv_d;
    logic [VEC_W-1:0]  ffvec_q, ffvec_d;
    logic [VEC_W-1:0]  vec_q, vec_d;

    logic [7:0] edge_w, close_w;
    logic       at_one_w, at_wrap_w, edge_hit_w, win_hit_w, miss_w, verdict_w;

    assign edge_w    = {1'b0, strobe_edge_i};
    assign close_w   = {1'b0, window_close_i};
    assign at_one_w  = (cnt_q == 8'd1);
    assign at_wrap_w = (cnt_q == cycle_length_i);
    assign miss_w    = (s_w != exp_q);
    // cnt never reaches 0, so a zero STROBE_EDGE can never produce an edge hit.
    assign edge_hit_w = en_i && (cnt_q == edge_w);
    // A zero STROBE_EDGE must also suppress the window, otherwise cnt > 0 would open it.
    assign win_hit_w  = en_i && cmp_mode_i && (edge_w != 8'd0) &&
                        (cnt_q > edge_w) && (cnt_q <= close_w);

    // Next-state for counter, expect latch, mismatch accumulator and results.
    always_comb begin
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        mism_d  = mism_q;
        valid_d = 1'b0;
        fail_d  = fail_q;
        fcnt_d  = fcnt_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        vec_d   = vec_q;

        if (at_wrap_w) begin
            cnt_d = 8'd1;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (at_one_w && en_i) begin
            exp_d  = exp_i;
            mask_d = mask_i;
        end

        if (edge_hit_w) begin
            mism_d = miss_w;
        end else if (win_hit_w) begin
            mism_d = mism_q | miss_w;
        end else if (at_one_w) begin
            mism_d = 1'b0;
        end

        // The verdict sees a compare landing on the wrap tick itself.
        verdict_w = mism_d & ~mask_q;

        if (clr_results_i) begin
            fail_d  = 1'b0;
            fcnt_d  = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
            vec_d   = '0;
        end else if (at_wrap_w) begin
            valid_d = 1'b1;
            fail_d  = verdict_w;
            vec_d   = vec_q + 1'b1;
            if (verdict_w) begin
                if (fcnt_q != {FCNT_W{1'b1}}) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
                if (!ffv_q) begin
                    ffv_d   = 1'b1;
                    ffvec_d = vec_q;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= 8'd1;
            exp_q   <= 1'b0;
            mask_q  <= 1'b0;
            mism_q  <= 1'b0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            fcnt_q  <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            vec_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            mism_q  <= mism_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            fcnt_q  <= fcnt_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            vec_q   <= vec_d;
        end
    end

    assign result_valid_o     = valid_q;
    assign fail_o             = fail_q;
    assign fail_count_o       = fcnt_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_vec_o   = ffvec_q;
    assign vec_index_o        = vec_q;

endmodule
`default_nettype wire

// File: tb/tb_strobe_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_strobe_compare
// Description : Self-checking bench for strobe_compare. A vector-level model
//               decides each verdict from the pin history and the strobe rules;
//               a negedge process compares every output against it each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strobe_compare;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, cmp_mode = 1'b0, dut_q = 1'b0;
    logic       exp_in = 1'b0, mask_in = 1'b0, clr = 1'b0;
    logic [7:0] cycle_length = 8'd10;
    logic [6:0] strobe_edge = 7'd5, window_close = 7'd0;

    logic        a_valid, a_fail, a_ffv, b_valid, b_fail, b_ffv;
    logic [15:0] a_cnt, a_ffvec, a_vec, b_ffvec, b_vec;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    strobe_compare #(.SYNC_STAGES(SS), .VEC_W(16), .FCNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cycle_length_i(cycle_length),
        .strobe_edge_i(strobe_edge), .window_close_i(window_close), .cmp_mode_i(cmp_mode),
        .dut_q_i(dut_q), .exp_i(exp_in), .mask_i(mask_in), .clr_results_i(clr),
        .result_valid_o(a_valid), .fail_o(a_fail), .fail_count_o(a_cnt),
        .first_fail_valid_o(a_ffv), .first_fail_vec_o(a_ffvec), .vec_index_o(a_vec));

    strobe_compare #(.SYNC_STAGES(SS), .VEC_W(16), .FCNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cycle_length_i(cycle_length),
        .strobe_edge_i(strobe_edge), .window_close_i(window_close), .cmp_mode_i(cmp_mode),
        .dut_q_i(dut_q), .exp_i(exp_in), .mask_i(mask_in), .clr_results_i(clr),
        .result_valid_o(b_valid), .fail_o(b_fail), .fail_count_o(b_cnt),
        .first_fail_valid_o(b_ffv), .first_fail_vec_o(b_ffvec), .vec_index_o(b_vec));

    int checks = 0, failures = 0;
    bit cmp_on = 0;

    // Model of the visible outputs.
    bit        m_valid, m_fail, m_ffv;
    int        m_cnt, m_cnt2;
    bit [15:0] m_ffvec, m_vec;

    // Pin value driven on each global tick (0 where reset cleared the synchronizer).
    bit pin_hist [32768];
    int gt = SS;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_fail = 0; m_cnt = 0; m_cnt2 = 0;
        m_ffv = 0; m_ffvec = '0; m_vec = '0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("result_valid", {31'd0, a_valid}, {31'd0, m_valid});
            chk("fail", {31'd0, a_fail}, {31'd0, m_fail});
            chk("fail_count", {16'd0, a_cnt}, m_cnt);
            chk("first_fail_valid", {31'd0, a_ffv}, {31'd0, m_ffv});
            chk("first_fail_vec", {16'd0, a_ffvec}, {16'd0, m_ffvec});
            chk("vec_index", {16'd0, a_vec}, {16'd0, m_vec});
            chk("sat_fail_count", {30'd0, b_cnt}, m_cnt2);
            chk("sat_valid_fail", {30'd0, b_valid, b_fail}, {30'd0, m_valid, m_fail});
            chk("sat_vec", {b_vec, b_ffvec}, {m_vec, m_ffvec});
            chk("sat_ffv", {31'd0, b_ffv}, {31'd0, m_ffv});
        end
    end

    task automatic do_reset();
        rst = 1; en = 0; clr = 0; dut_q = 0;
        repeat (2) begin
            pin_hist[gt] = 0;
            @(posedge clk);
            gt++;
            model_clear();
            #2;
        end
        rst = 0; en = 1;
    endtask

    // One tick with EN=0 at cnt==1 (between vectors), optionally clearing results.
    task automatic idle_tick(input bit c);
        en = 0; clr = c; dut_q = 0; pin_hist[gt] = 0;
        @(posedge clk);
        gt++;
        m_valid = 0;
        if (c) model_clear();
        #2;
        clr = 0; en = 1;
    endtask

    // Drive one complete vector; pat[p] is the pin value while cnt==p.
    task automatic run_vector(input int cl, input int se, input int wc, input bit mode,
                              input bit e, input bit m, input logic [63:0] pat,
                              input int pause_pos, input int pause_len,
                              input bit clr_wrap, input int abort_pos);
        bit mm = 0;
        bit en_now, hit, f;
        int p = 1;
        int pl = pause_len;
        cycle_length = cl[7:0]; strobe_edge = se[6:0]; window_close = wc[6:0];
        cmp_mode = mode; exp_in = e; mask_in = m;
        forever begin
            en_now = !(p == pause_pos && pl > 0);
            if (!en_now) pl--;
            en = en_now; dut_q = pat[p]; rst = (p == abort_pos); clr = clr_wrap && (p == cl);
            hit = en_now && se != 0 && se <= cl && (p == se || (mode && p > se && p <= wc));
            if (hit && (pin_hist[gt-SS] != e)) mm = 1;
            pin_hist[gt] = pat[p];
            @(posedge clk);
            if (rst) begin
                pin_hist[gt] = 0; pin_hist[gt-1] = 0;
                gt++;
                model_clear();
                #2;
                rst = 0; clr = 0; en = 1;
                return;
            end
            gt++;
            m_valid = 0;
            if (clr) begin
                model_clear();
            end else if (p == cl) begin
                f = mm & !m;
                m_valid = 1; m_fail = f;
                if (f) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (!m_ffv) begin m_ffv = 1; m_ffvec = m_vec; end
                end
                m_vec++;
            end
            #2;
            if (p == cl) break;
            if (en_now) p++;
        end
        clr = 0;
    endtask

    initial begin
        logic [63:0] ones, zeros, pat;
        int cl, se, wc, pp, plen, ab;
        bit e, m;
        ones  = '1;
        zeros = '0;

        do_reset();
        cmp_on = 1;
        chk("reset_vec_index", {16'd0, a_vec}, 32'd0);
        chk("reset_fail_count", {16'd0, a_cnt}, 32'd0);
        chk("reset_valid_fail", {30'd0, a_valid, a_fail}, 32'd0);

        // Three passing EDGE vectors.
        repeat (3) run_vector(10, 5, 0, 0, 1, 0, ones, 0, 0, 0, 0);
        chk("t1_vec_index", {16'd0, a_vec}, 32'd3);
        chk("t1_fail_count", {16'd0, a_cnt}, 32'd0);
        chk("t1_fail", {31'd0, a_fail}, 32'd0);

        // Failure on vector 2 only.
        idle_tick(1);
        run_vector(10, 5, 0, 0, 0, 0, zeros, 0, 0, 0, 0);
        run_vector(10, 5, 0, 0, 0, 0, zeros, 0, 0, 0, 0);
        run_vector(10, 5, 0, 0, 0, 0, ones, 0, 0, 0, 0);
        chk("t2_fail", {31'd0, a_fail}, 32'd1);
        chk("t2_fail_count", {16'd0, a_cnt}, 32'd1);
        chk("t2_first_fail_vec", {16'd0, a_ffvec}, 32'd2);
        chk("t2_first_fail_valid", {31'd0, a_ffv}, 32'd1);

        // WINDOW glitch reaching the compare at cnt=6 (fails) and cnt=8 (passes).
        idle_tick(1);
        pat = ones; pat[4] = 1'b0;
        run_vector(10, 3, 7, 1, 1, 0, pat, 0, 0, 0, 0);
        chk("t3_glitch_in", {31'd0, a_fail}, 32'd1);
        pat = ones; pat[6] = 1'b0;
        run_vector(10, 3, 7, 1, 1, 0, pat, 0, 0, 0, 0);
        chk("t3_glitch_out", {31'd0, a_fail}, 32'd0);

        // Mask, then saturation of the 2-bit counter.
        idle_tick(1);
        run_vector(10, 5, 0, 0, 0, 1, ones, 0, 0, 0, 0);
        chk("t4_mask_fail", {31'd0, a_fail}, 32'd0);
        chk("t4_mask_count", {16'd0, a_cnt}, 32'd0);
        repeat (5) run_vector(10, 5, 0, 0, 0, 0, ones, 0, 0, 0, 0);
        chk("t4_sat_count", {30'd0, b_cnt}, 32'd3);
        chk("t4_wide_count", {16'd0, a_cnt}, 32'd5);

        // CLR on a failing wrap tick, then reset at cnt=4.
        run_vector(10, 5, 0, 0, 0, 0, ones, 0, 0, 1, 0);
        chk("t5_clr_valid", {31'd0, a_valid}, 32'd0);
        chk("t5_clr_counts", {a_cnt, a_vec}, 32'd0);
        chk("t5_clr_flags", {30'd0, a_ffv, a_fail}, 32'd0);
        run_vector(10, 5, 0, 0, 0, 0, ones, 0, 0, 0, 0);
        run_vector(10, 5, 0, 0, 0, 0, ones, 0, 0, 0, 4);
        chk("t5_rst_outputs", {a_cnt, a_vec}, 32'd0);
        chk("t5_rst_flags", {29'd0, a_valid, a_ffv, a_fail}, 32'd0);
        run_vector(10, 5, 0, 0, 1, 0, ones, 0, 0, 0, 0);
        chk("t5_restart_vec", {16'd0, a_vec}, 32'd1);

        // EN pause of 6 ticks mid-vector.
        run_vector(10, 5, 0, 0, 0, 0, ones, 3, 6, 0, 0);
        chk("t6_pause_fail", {31'd0, a_fail}, 32'd1);
        chk("t6_pause_vec", {16'd0, a_vec}, 32'd2);

        // Randomized vectors.
        for (int n = 0; n < 300; n++) begin
            cl = $urandom_range(2, 30);
            case ($urandom_range(0, 9))
                0:       se = 0;
                1:       se = cl + $urandom_range(1, 3);
                default: se = $urandom_range(2, cl);
            endcase
            wc = $urandom_range(0, cl + 2);
            e  = 1'($urandom_range(0, 1));
            m  = ($urandom_range(0, 99) < 15);
            for (int b = 0; b < 64; b++)
                pat[b] = ($urandom_range(0, 99) < 85) ? e : !e;
            pp = 0; plen = 0;
            if (cl >= 3 && $urandom_range(0, 99) < 30) begin
                pp = $urandom_range(2, cl - 1); plen = $urandom_range(1, 6);
            end
            ab = (cl >= 3 && $urandom_range(0, 99) < 3) ? $urandom_range(2, cl - 1) : 0;
            run_vector(cl, se, wc, 1'($urandom_range(0, 1)), e, m, pat, pp, plen,
                       ($urandom_range(0, 99) < 8), ab);
            if ($urandom_range(0, 99) < 5) idle_tick(1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
